// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request path: command word and port identifier.
package sdram_pkg;

  localparam int SDRAM_ADDR_DEPTH = 25;

  typedef logic port_id_t;

  typedef struct packed {
    logic                        we;
    logic [SDRAM_ADDR_DEPTH-1:0] addr;
    logic [7:0]                  wdata;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO of port IDs, one entry per outstanding SDRAM read.
// Latency: head valid the cycle after push; push and pop may share a cycle.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module sdram_tag_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output port_id_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  port_id_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the byte-wide SDRAM controller; routes read data back by tag.
// Latency: command on mem_* the cycle after req; read data on p*_val one cycle after mem_val.
// Backpressure: command held until mem_rdy; reads not granted while all tags are in flight.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_DEPTH  = SDRAM_ADDR_DEPTH,
  parameter int RD_TAGS     = 4,
  parameter int P0_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_DEPTH-1:0] p0_addr,
  input  logic [7:0]            p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_val,
  output logic [7:0]            p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_DEPTH-1:0] p1_addr,
  input  logic [7:0]            p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_val,
  output logic [7:0]            p1_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_DEPTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_rdy,
  input  logic                  mem_val,
  input  logic [7:0]            mem_rdata,
  output logic                  err
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state;
  sdram_cmd_t cmd;
  port_id_t   cmd_port;
  port_id_t   rr_next;

  logic       p0_elig;
  logic       p1_elig;
  logic       grant_vld;
  port_id_t   grant_id;
  logic       accept;

  logic       tag_push;
  logic       tag_full;
  logic       tag_empty;
  port_id_t   tag_head;
  logic       pop_ok;

  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign accept    = (state == ISSUE) && (mem_rd || mem_wr) && mem_rdy;
  assign tag_push  = accept && mem_rd;
  assign pop_ok    = mem_val && !tag_empty;

  // Reads are held back while every tag is in flight; writes never are.
  always_comb begin
    p0_elig   = p0_req && (p0_we || !tag_full);
    p1_elig   = p1_req && (p1_we || !tag_full);
    grant_vld = p0_elig || p1_elig;
    grant_id  = 1'b0;
    if (p0_elig && p1_elig)
      grant_id = (P0_PRIORITY != 0) ? 1'b0 : rr_next;
    else if (p1_elig)
      grant_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cmd      <= '0;
      cmd_port <= 1'b0;
      rr_next  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            if (grant_id) begin
              cmd    <= '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
              mem_rd <= !p1_we;
              mem_wr <= p1_we;
              p1_ack <= 1'b1;
            end else begin
              cmd    <= '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
              mem_rd <= !p0_we;
              mem_wr <= p0_we;
              p0_ack <= 1'b1;
            end
            cmd_port <= grant_id;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            rr_next <= ~cmd_port;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p0_val   <= 1'b0;
      p1_val   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      err      <= 1'b0;
    end else begin
      p0_val <= pop_ok && (tag_head == 1'b0);
      p1_val <= pop_ok && (tag_head == 1'b1);
      if (pop_ok && (tag_head == 1'b0)) p0_rdata <= mem_rdata;
      if (pop_ok && (tag_head == 1'b1)) p1_rdata <= mem_rdata;
      if (mem_val && tag_empty) err <= 1'b1;
    end
  end

  sdram_tag_fifo #(
    .DEPTH (RD_TAGS)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tag_push),
    .push_id (cmd_port),
    .pop     (mem_val),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty)
  );

endmodule
